// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, reset level, word constants.
package muldiv_unit_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned ProdW = 64;
    localparam int unsigned CntW  = 5;

    localparam logic             RstEnable = 1'b0;
    localparam logic [DataW-1:0] ZeroWord  = '0;
    localparam logic [DataW-1:0] OnesWord  = '1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // HI/LO result pair as written toward the register file
    typedef struct packed {
        logic [DataW-1:0] hi;
        logic [DataW-1:0] lo;
    } result_t;

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider on operand magnitudes with sign fix-up and divide-by-zero bypass.
module div_core
    import muldiv_unit_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [DataW-1:0] dividend,
    input  logic [DataW-1:0] divisor,
    output logic             done_c,
    output logic [DataW-1:0] quot_c,
    output logic [DataW-1:0] rem_c
);

    logic             active;
    logic             div_zero;
    logic             neg_quot;
    logic             neg_rem;
    logic [CntW-1:0]  cnt;
    logic [DataW-1:0] rem_q;
    logic [DataW-1:0] quot_q;
    logic [DataW-1:0] dvs_q;
    logic [DataW-1:0] dvd_q;

    logic [DataW:0]   shifted;
    logic             fits;
    logic [DataW-1:0] diff;
    logic [DataW-1:0] rem_step;
    logic [DataW-1:0] quot_step;
    logic [DataW-1:0] dvd_mag;
    logic [DataW-1:0] dvs_mag;

    // Operand magnitudes presented at start
    always_comb begin
        dvd_mag = (is_signed && dividend[DataW-1]) ? DataW'(-dividend) : dividend;
        dvs_mag = (is_signed && divisor[DataW-1])  ? DataW'(-divisor)  : divisor;
    end

    // One restoring step: shift in the next dividend bit and subtract if it fits
    always_comb begin
        shifted   = {rem_q, quot_q[DataW-1]};
        fits      = (shifted >= {1'b0, dvs_q});
        diff      = DataW'(shifted - {1'b0, dvs_q});
        rem_step  = fits ? diff : shifted[DataW-1:0];
        quot_step = {quot_q[DataW-2:0], fits};
    end

    // Completion and sign-corrected results, valid in the cycle done_c is high
    always_comb begin
        done_c = active && (div_zero || (cnt == CntW'(DataW - 1)));
        if (div_zero) begin
            quot_c = OnesWord;
            rem_c  = dvd_q;
        end else begin
            quot_c = neg_quot ? DataW'(-quot_step) : quot_step;
            rem_c  = neg_rem  ? DataW'(-rem_step)  : rem_step;
        end
    end

    // Iteration state: load on start, step while active, drop on done or cancel
    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RstEnable) begin
            active   <= 1'b0;
            div_zero <= 1'b0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            rem_q    <= ZeroWord;
            quot_q   <= ZeroWord;
            dvs_q    <= ZeroWord;
            dvd_q    <= ZeroWord;
        end else if (cancel) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active   <= 1'b1;
            div_zero <= (divisor == ZeroWord);
            neg_quot <= is_signed && (dividend[DataW-1] ^ divisor[DataW-1]);
            neg_rem  <= is_signed && dividend[DataW-1];
            cnt      <= '0;
            rem_q    <= ZeroWord;
            quot_q   <= dvd_mag;
            dvs_q    <= dvs_mag;
            dvd_q    <= dividend;
        end else if (active) begin
            if (done_c) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt    <= cnt + CntW'(1);
                rem_q  <= rem_step;
                quot_q <= quot_step;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply, iterative divide, flushable by cancel.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [DataW-1:0] opa_i,
    input  logic [DataW-1:0] opb_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             we_o,
    output logic [DataW-1:0] hi_o,
    output logic [DataW-1:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    state_e           state;
    state_e           state_next;
    logic             accept;
    logic             div_start;
    logic             req_is_mul;
    logic             div_done;
    logic [DataW-1:0] div_quot;
    logic [DataW-1:0] div_rem;
    op_e              op_q;
    logic [DataW-1:0] opa_q;
    logic [DataW-1:0] opb_q;
    logic [ProdW-1:0] opa_ext;
    logic [ProdW-1:0] opb_ext;
    logic [ProdW-1:0] product;
    result_t          res_q;

    assign req_is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RstEnable) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; cancel overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_i) state_next = req_is_mul ? ST_MUL : ST_DIV;
            ST_MUL:  state_next = ST_DONE;
            ST_DIV:  if (div_done) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (cancel_i) state_next = ST_IDLE;
    end

    // Outputs and control strobes decoded from state
    always_comb begin
        busy_o    = (state != ST_IDLE);
        we_o      = (state == ST_DONE) && !cancel_i;
        accept    = (state == ST_IDLE) && start_i && !cancel_i;
        div_start = accept && !req_is_mul;
    end

    // Full 64-bit product from sign- or zero-extended latched operands
    always_comb begin
        if (op_q == OP_MULT) begin
            opa_ext = {{DataW{opa_q[DataW-1]}}, opa_q};
            opb_ext = {{DataW{opb_q[DataW-1]}}, opb_q};
        end else begin
            opa_ext = {ZeroWord, opa_q};
            opb_ext = {ZeroWord, opb_q};
        end
        product = opa_ext * opb_ext;
    end

    div_core u_div_core (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .is_signed (op_i == OP_DIV),
        .cancel    (cancel_i),
        .dividend  (opa_i),
        .divisor   (opb_i),
        .done_c    (div_done),
        .quot_c    (div_quot),
        .rem_c     (div_rem)
    );

    // Operand capture on accept; result capture on entry to DONE unless flushed
    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RstEnable) begin
            op_q  <= OP_MULT;
            opa_q <= ZeroWord;
            opb_q <= ZeroWord;
            res_q <= '{hi: ZeroWord, lo: ZeroWord};
        end else begin
            if (accept) begin
                op_q  <= op_e'(op_i);
                opa_q <= opa_i;
                opb_q <= opb_i;
            end
            if (!cancel_i) begin
                if (state == ST_MUL) begin
                    res_q <= result_t'(product);
                end else if (state == ST_DIV && div_done) begin
                    res_q <= '{hi: div_rem, lo: div_quot};
                end
            end
        end
    end

    assign hi_o = res_q.hi;
    assign lo_o = res_q.lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, cancel, held start and mid-op reset.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        cancel_i;
    logic        busy_o;
    logic        we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .op_i     (op_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .cancel_i (cancel_i),
        .busy_o   (busy_o),
        .we_o     (we_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request before an edge; return 1ns after the accepting edge
    task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        opa_i   = a;
        opb_i   = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Edges after acceptance until we_o seen; -1 if the budget runs out
    task automatic wait_we(output int edges);
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (we_o) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic count_we(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (we_o) cnt++;
        end
    endtask

    task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int edges;
        issue(op, a, b);
        check({tag, " busy"}, 64'(busy_o), 64'(1));
        wait_we(edges);
        check({tag, " cycle"}, 64'(edges + 1), 64'(exp_cyc));
        check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
        @(posedge clk);
        #1;
        check({tag, " idle after"}, 64'({busy_o, we_o}), 64'(0));
        last_hi = exp_hi;
        last_lo = exp_lo;
    endtask

    initial begin
        int cnt;
        int edges;
        resetn   = 1'b0;
        start_i  = 1'b0;
        cancel_i = 1'b0;
        op_i     = 2'b00;
        opa_i    = 32'h0;
        opb_i    = 32'h0;

        #12;
        check("reset busy/we", 64'({busy_o, we_o}), 64'(0));
        check("reset hi", 64'(hi_o), 64'(0));
        check("reset lo", 64'(lo_o), 64'(0));
        @(negedge clk);
        resetn = 1'b1;

        run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'h3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'h3, 2, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);
        run_op("div -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 2, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Flush during iteration 10 of an unsigned divide
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        cancel_i = 1'b1;
        #1;
        check("cancel div we", 64'(we_o), 64'(0));
        @(posedge clk);
        #1;
        check("cancel div idle", 64'({busy_o, we_o}), 64'(0));
        check("cancel div hi", 64'(hi_o), 64'(last_hi));
        check("cancel div lo", 64'(lo_o), 64'(last_lo));
        cancel_i = 1'b0;
        run_op("multu 3x4", OP_MULTU, 32'd3, 32'd4, 2, 32'd0, 32'd12);

        // Flush in DONE suppresses the write strobe
        issue(OP_MULT, 32'd5, 32'd6);
        @(posedge clk);
        #1;
        check("done pre-cancel we", 64'(we_o), 64'(1));
        cancel_i = 1'b1;
        #1;
        check("done cancel we", 64'(we_o), 64'(0));
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        check("done cancel idle", 64'({busy_o, we_o}), 64'(0));
        count_we(4, cnt);
        check("done cancel no we", 64'(cnt), 64'(0));

        // start_i held through a divide with operands changing after acceptance
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OP_DIVU;
        opa_i   = 32'd100;
        opb_i   = 32'd7;
        @(posedge clk);
        #1;
        opa_i = 32'd50;
        opb_i = 32'd3;
        wait_we(edges);
        check("held cycle", 64'(edges + 1), 64'(33));
        check("held hi", 64'(hi_o), 64'(2));
        check("held lo", 64'(lo_o), 64'(14));
        start_i = 1'b0;
        count_we(40, cnt);
        check("held extra we", 64'(cnt), 64'(0));
        check("held idle", 64'(busy_o), 64'(0));
        last_hi = 32'd2;
        last_lo = 32'd14;

        // start with cancel in IDLE is refused
        @(negedge clk);
        start_i  = 1'b1;
        cancel_i = 1'b1;
        op_i     = OP_MULT;
        opa_i    = 32'd9;
        opb_i    = 32'd9;
        @(posedge clk);
        #1;
        check("start+cancel busy", 64'(busy_o), 64'(0));
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        count_we(3, cnt);
        check("start+cancel no we", 64'(cnt), 64'(0));
        check("start+cancel lo", 64'(lo_o), 64'(last_lo));

        // Asynchronous reset in the middle of a divide
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst mid busy/we", 64'({busy_o, we_o}), 64'(0));
        check("rst mid hi", 64'(hi_o), 64'(0));
        check("rst mid lo", 64'(lo_o), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        count_we(40, cnt);
        check("rst no we", 64'(cnt), 64'(0));
        run_op("post rst divu", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; op encodings SHALL come from the shared define file.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset; assertion SHALL clear state immediately, and release SHALL take effect synchronously to clk.
REQ-004 start_i  input  1  request strobe; sampled only in IDLE.
REQ-005 op_i  input  2  operation: MULT, MULTU, DIV, DIVU.
REQ-006 opa_i  input  32  multiplicand / dividend.
REQ-007 opb_i  input  32  multiplier / divisor.
REQ-008 cancel_i  input  1  pipeline flush (exception); aborts any operation.
REQ-009 busy_o  output  1  high while an operation is in flight, including the DONE cycle.
REQ-010 we_o  output  1  one-cycle write strobe toward the HI/LO register pair.
REQ-011 hi_o  output  32  HI result (product[63:32] or remainder).
REQ-012 lo_o  output  32  LO result (product[31:0] or quotient).

Function
REQ-013 The block SHALL have four states: IDLE, MUL, DIV, DONE; busy_o SHALL equal (state != IDLE).
REQ-014 In IDLE, start_i=1 with cancel_i=0 SHALL latch op_i/opa_i/opb_i and move to MUL (MULT/MULTU) or DIV (DIV/DIVU).
REQ-015 start_i SHALL be ignored in every state other than IDLE; operands SHALL not change after acceptance.
REQ-016 MUL SHALL compute the full 64-bit product (signed for MULT, unsigned for MULTU) in one cycle and then go to DONE; we_o SHALL be high in the 2nd cycle after the accepting edge.
REQ-017 DIV SHALL run a radix-2 restoring divide on magnitudes for exactly 32 cycles and then go to DONE; we_o SHALL be high 33 cycles after the accepting edge.
REQ-018 For signed DIV, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-019 Signed overflow (0x8000_0000 / 0xFFFF_FFFF) SHALL yield lo_o=0x8000_0000 and hi_o=0x0000_0000.
REQ-020 A divisor of zero SHALL skip iteration: DIV SHALL go to DONE after one cycle with hi_o=opa, lo_o=0xFFFF_FFFF, for both signed and unsigned.
REQ-021 DONE SHALL assert we_o for exactly one cycle and then return to IDLE; a new start_i SHALL be accepted on the first IDLE cycle.
REQ-022 hi_o/lo_o SHALL be registered, SHALL be valid whenever we_o=1, and SHALL hold their last value otherwise.
REQ-023 cancel_i=1 in any state SHALL force IDLE on the next edge with we_o=0, including in DONE, where the write SHALL be suppressed; hi_o/lo_o SHALL not change.
REQ-024 When start_i and cancel_i are both high in IDLE, cancel SHALL win and the request SHALL not be accepted.

Reset
REQ-025 resetn=0 SHALL force state=IDLE, busy_o=0, we_o=0, hi_o=lo_o=ZeroWord, and clear the iteration counter and partial remainder.
REQ-026 Reset mid-operation SHALL discard the operation with no we_o pulse.

Structure
REQ-027 The op encodings, ZeroWord and RstEnable SHALL reside in the shared define file; state encodings SHALL be local.
REQ-028 The iterative divider (counter, partial remainder, quotient shift register, sign fix-up) SHALL be one sub-module, div_core, with start/done handshake and its own cancel; multiply and the FSM SHALL stay in muldiv_unit.

Verification
REQ-029 MULT 0xFFFF_FFFE x 0x0000_0003 -> we_o in cycle 2, hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFFA; MULTU of the same operands -> hi_o=0x0000_0002, lo_o=0xFFFF_FFFA.
REQ-030 DIV 0xFFFF_FFF9 (-7) / 2 -> we_o 33 cycles after acceptance, lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF; DIVU 100/7 -> lo_o=14, hi_o=2.
REQ-031 DIV 0x8000_0000 / 0xFFFF_FFFF -> lo_o=0x8000_0000, hi_o=0; DIVU 5/0 -> we_o in cycle 2, hi_o=5, lo_o=0xFFFF_FFFF.
REQ-032 DIVU started, cancel_i pulsed at iteration 10 -> IDLE next cycle, no we_o, hi_o/lo_o unchanged; an immediate new MULTU 3x4 -> lo_o=12.
REQ-033 start_i held high throughout a DIV -> exactly one we_o per accepted operation; start_i with cancel_i in IDLE -> no acceptance, busy_o stays 0.
REQ-034 resetn dropped during the DIV state -> outputs zero immediately, no we_o after release, and the next op completes correctly.
